fetch_line_fill_bridge: RTL and testbench
=========================================

Name: fetch_line_fill_bridge

Overview:
- Sits directly downstream of the instruction cache's read-only memory master port.
- Accepts one line-fill request at a time: word address plus burst length.
- Converts each request into a sequence of single-word reads on a simple pipelined request/response bus.
- Returns the line beats in order, starting from the line-aligned base, as the cache's line-fill write path expects.

Parameters:
MAX_OUTSTANDING, 4, maximum bus reads issued but not yet answered (1..16).
RLEN_W, 5, width of the burst-length field (beats = rlen+1).

Ports:
clk  input  1  clock
rst  input  1  reset
req  input  1  line-fill request from cache; held until acked
req_addr  input  30  word address (byte address [31:2]); need not be line-aligned
req_rlen  input  RLEN_W  beats minus one; always 2^n-1
req_ack  output  1  request accepted (single-cycle)
rvalid  output  1  one returned beat valid
rdata  output  32  returned beat data
bus_req  output  1  single-word read request valid
bus_addr  output  32  byte address of read, low 2 bits zero
bus_ready  input  1  bus accepts request this cycle
bus_rvalid  input  1  read response valid (in order, no backpressure)
bus_rdata  input  32  read response data
busy  output  1  fill in progress
protocol_err  output  1  sticky: response received with nothing outstanding

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: state IDLE; req_ack, rvalid, bus_req, busy, protocol_err all 0; rdata 0; all counters 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ack = req & (state==IDLE), combinational.
  - On ack, latch base = req_addr & ~{(30-RLEN_W)'0, req_rlen}, issue_cnt=0, resp_cnt=0, last=req_rlen.
  - Next state ISSUE.
- ISSUE:
  - bus_req = (outstanding < MAX_OUTSTANDING) | bus_rvalid; a response in the same cycle frees a slot.
  - bus_addr = {base + issue_cnt, 2'b00}.
  - Accept = bus_req & bus_ready: issue_cnt++ and outstanding++.
  - On accept of beat last, go to DRAIN.
  - bus_req and bus_addr stay stable until accepted.
- DRAIN: bus_req=0. When resp_cnt reaches last+1 (final rvalid emitted), go to IDLE.
- Responses:
  - Each bus_rvalid with outstanding>0: outstanding--, resp_cnt++.
  - Next cycle rvalid=1 and rdata=bus_rdata; fixed 1-cycle registered latency.
  - Simultaneous accept and response: outstanding unchanged.
- Beat order: strictly base, base+1, … base+last. The first beat is word 0 of the line, not the requested word.
- busy = (state != IDLE) | rvalid pending.
- No new ack until the final rvalid of the current fill has been emitted. The earliest next ack is the cycle after that rvalid.
- req_addr and req_rlen are ignored outside the ack cycle.
- Address arithmetic is 30-bit. Base alignment guarantees base+last stays within the aligned block, so there is no wrap.
- Spurious response (bus_rvalid with outstanding==0, any state):
  - Dropped: no rvalid, counters unchanged.
  - protocol_err set until rst.
- rlen=0 gives a single-beat fill: ISSUE→DRAIN on the first accept.
- Reset mid-fill:
  - Everything returns to IDLE and counters clear.
  - Responses still in flight arrive with outstanding==0 and set protocol_err, so bus and bridge must be reset together.
- MAX_OUTSTANDING=1 gives a strictly serial issue/response.

Test Plan:
- Aligned fill: req_addr=0x0000_0100, rlen=7, bus_ready=1, response latency 2 → bus_addr 0x400..0x41C in order; 8 rvalid beats with matching data; req_ack for exactly 1 cycle; back in IDLE the cycle after the 8th rvalid.
- Unaligned request: req_addr=0x0000_0105, rlen=7 → base 0x100; first bus_addr 0x400, last 0x41C; beat order unchanged.
- Outstanding limit: MAX_OUTSTANDING=4, responses withheld → exactly 4 accepts then bus_req=0. One bus_rvalid in a cycle → bus_req=1 in that same cycle.
- Backpressure: bus_ready toggling 1,0,0,1,… → bus_addr held stable while bus_req & ~bus_ready; no duplicate or skipped address.
- Back-to-back requests: req held high across two fills (rlen=3) → second req_ack no earlier than the cycle after the 4th rvalid of the first fill.
- Errors and reset: spurious bus_rvalid in IDLE → protocol_err=1, no rvalid. rst asserted mid-fill after 3 of 8 beats → all outputs 0 next cycle; a new fill then completes correctly.

Source files
------------

// File: rtl/fetch_line_fill_bridge_if.sv
// Line-fill request/return port plus pipelined single-word read bus.
// The bridge uses the master view; the cache and bus side use the slave view.
interface fetch_line_fill_bridge_if #(
  parameter int unsigned RLEN_W = 5
) ();
  logic              req;
  logic [29:0]       req_addr;
  logic [RLEN_W-1:0] req_rlen;
  logic              req_ack;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              bus_req;
  logic [31:0]       bus_addr;
  logic              bus_ready;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;
  logic              busy;
  logic              protocol_err;

  modport master (
    input  req, req_addr, req_rlen, bus_ready, bus_rvalid, bus_rdata,
    output req_ack, rvalid, rdata, bus_req, bus_addr, busy, protocol_err
  );

  modport slave (
    output req, req_addr, req_rlen, bus_ready, bus_rvalid, bus_rdata,
    input  req_ack, rvalid, rdata, bus_req, bus_addr, busy, protocol_err
  );
endinterface

// File: rtl/fetch_line_fill_bridge.sv
// Turns one instruction-cache line-fill request into in-order single-word bus
// reads, always starting from the line-aligned base, and returns the beats.
module fetch_line_fill_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RLEN_W          = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_line_fill_bridge_if.master io
);
  localparam int unsigned       CNT_W    = RLEN_W + 1;
  localparam int unsigned       OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]  MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]  OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0]  OUT_ONE  = OUT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [29:0]       base_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  resp_cnt_q;
  logic [RLEN_W-1:0] last_q;
  logic [OUT_W-1:0]  outstanding_q;
  logic [OUT_W-1:0]  outstanding_d;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              protocol_err_q;

  logic              ack_s;
  logic              bus_req_s;
  logic              issue_fire_s;
  logic              resp_fire_s;
  logic              spurious_s;
  logic              last_issue_s;
  logic              fill_done_s;
  logic [CNT_W-1:0]  last_ext_s;
  logic [29:0]       req_base_s;
  logic [29:0]       issue_addr_s;

  // A response in the same cycle frees a slot, so it may re-open the request.
  always_comb begin
    ack_s = io.req & (state_q == IDLE);
    if (state_q == ISSUE) begin
      bus_req_s = (outstanding_q < MAX_OUT) | io.bus_rvalid;
    end else begin
      bus_req_s = 1'b0;
    end
    issue_fire_s = bus_req_s & io.bus_ready;
    resp_fire_s  = io.bus_rvalid & (outstanding_q != OUT_ZERO);
    spurious_s   = io.bus_rvalid & (outstanding_q == OUT_ZERO);
    last_ext_s   = {1'b0, last_q};
    last_issue_s = (issue_cnt_q == last_ext_s);
    fill_done_s  = (resp_cnt_q == (last_ext_s + CNT_ONE));
    req_base_s   = io.req_addr & ~{{(30 - RLEN_W){1'b0}}, io.req_rlen};
    issue_addr_s = base_q + 30'(issue_cnt_q);
  end

  // Outstanding-read count; an accept and a response in one cycle cancel out.
  always_comb begin
    case ({issue_fire_s, resp_fire_s})
      2'b10:   outstanding_d = outstanding_q + OUT_ONE;
      2'b01:   outstanding_d = outstanding_q - OUT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Fill sequencer with its counters and the registered beat-return path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      base_q         <= 30'd0;
      issue_cnt_q    <= CNT_ZERO;
      resp_cnt_q     <= CNT_ZERO;
      last_q         <= {RLEN_W{1'b0}};
      outstanding_q  <= OUT_ZERO;
      rvalid_q       <= 1'b0;
      rdata_q        <= 32'd0;
      protocol_err_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rvalid_q      <= resp_fire_s;
      if (resp_fire_s) begin
        rdata_q    <= io.bus_rdata;
        resp_cnt_q <= resp_cnt_q + CNT_ONE;
      end
      // Responses with nothing outstanding are dropped but remembered.
      if (spurious_s) begin
        protocol_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (ack_s) begin
            base_q      <= req_base_s;
            issue_cnt_q <= CNT_ZERO;
            resp_cnt_q  <= CNT_ZERO;
            last_q      <= io.req_rlen;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_fire_s) begin
            issue_cnt_q <= issue_cnt_q + CNT_ONE;
            if (last_issue_s) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final beat is on rvalid this cycle; the next ack may follow.
          if (fill_done_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io.req_ack      = ack_s;
  assign io.bus_req      = bus_req_s;
  assign io.bus_addr     = {issue_addr_s, 2'b00};
  assign io.rvalid       = rvalid_q;
  assign io.rdata        = rdata_q;
  assign io.busy         = (state_q != IDLE) | rvalid_q;
  assign io.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_fetch_line_fill_bridge.sv
// Directed bench for fetch_line_fill_bridge: an in-order bus memory with fixed
// latency, a queue-based fill model checked every cycle, and literal pins.
module tb_fetch_line_fill_bridge;
  localparam int MAXO = 4;
  localparam int RW   = 5;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_line_fill_bridge_if #(.RLEN_W(RW)) bif ();
  fetch_line_fill_bridge #(.MAX_OUTSTANDING(MAXO), .RLEN_W(RW)) dut (
    .clk(clk),
    .rst(rst),
    .io (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic       hold       = 1'b0;
  logic       inject     = 1'b0;
  logic       ready_mode = 1'b0;
  logic [3:0] ready_pat  = 4'b1001;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] rd_log[$];
  logic        resp_real;

  logic        m_active   = 1'b0;
  int          m_inflight = 0;
  logic        m_perr     = 1'b0;
  logic        m_rv_pend  = 1'b0;
  logic [29:0] issue_q[$];
  logic [29:0] deliver_q[$];

  int   dut_acks    = 0;
  int   rv_count    = 0;
  int   last_rv_cyc = 0;
  int   last_ack_cyc = 0;
  int   fills_done  = 0;
  logic full_resp_req_seen = 1'b0;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return 32'hC0DE_0000 + {16'h0000, w[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus memory drives responses, then every output is compared with the model.
  always @(negedge clk) begin
    logic        exp_ack;
    logic        exp_breq;
    logic        resp_ok;
    logic        spur;
    logic        acc_exp;
    logic [29:0] base;
    int          beats;
    #1;
    bif.bus_ready = (ready_mode == 1'b0) ? 1'b1 : ready_pat[2'(cyc % 4)];
    resp_real = !hold && (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    if (resp_real) begin
      bif.bus_rvalid = 1'b1;
      bif.bus_rdata  = mem_word(pend_addr[0][31:2]);
    end else if (inject) begin
      bif.bus_rvalid = 1'b1;
      bif.bus_rdata  = 32'hDEAD_BEEF;
    end else begin
      bif.bus_rvalid = 1'b0;
      bif.bus_rdata  = 32'h0000_0000;
    end
    #1;
    if (rst) begin
      m_active = 1'b0; m_inflight = 0; m_perr = 1'b0; m_rv_pend = 1'b0;
      issue_q.delete(); deliver_q.delete();
      pend_addr.delete(); pend_due.delete();
    end else begin
      exp_ack  = bif.req && !m_active;
      resp_ok  = bif.bus_rvalid && (m_inflight > 0);
      spur     = bif.bus_rvalid && (m_inflight == 0);
      exp_breq = m_active && (issue_q.size() > 0) && ((m_inflight < MAXO) || bif.bus_rvalid);
      acc_exp  = exp_breq && bif.bus_ready;

      chk("req_ack", 32'(bif.req_ack), 32'(exp_ack));
      chk("busy", 32'(bif.busy), 32'(m_active));
      chk("bus_req", 32'(bif.bus_req), 32'(exp_breq));
      if (exp_breq) chk("bus_addr", bif.bus_addr, {issue_q[0], 2'b00});
      chk("rvalid", 32'(bif.rvalid), 32'(m_rv_pend));
      if (m_rv_pend) begin
        chk("beat_expected", 32'(deliver_q.size() > 0), 32'd1);
        if (deliver_q.size() > 0) begin
          chk("rdata", bif.rdata, mem_word(deliver_q[0]));
          void'(deliver_q.pop_front());
          if (deliver_q.size() == 0) begin
            m_active = 1'b0;
            fills_done++;
          end
        end
      end
      chk("protocol_err", 32'(bif.protocol_err), 32'(m_perr));

      if ((m_inflight == MAXO) && bif.bus_rvalid && bif.bus_req) full_resp_req_seen = 1'b1;
      if (acc_exp) void'(issue_q.pop_front());
      m_inflight = m_inflight + (acc_exp ? 1 : 0) - (resp_ok ? 1 : 0);
      m_rv_pend  = resp_ok;
      if (spur) m_perr = 1'b1;
      if (exp_ack) begin
        beats = int'(bif.req_rlen) + 1;
        base  = bif.req_addr - 30'(int'(bif.req_addr) % beats);
        for (int k = 0; k < beats; k++) begin
          issue_q.push_back(base + 30'(k));
          deliver_q.push_back(base + 30'(k));
        end
        m_active = 1'b1;
      end

      if (bif.req_ack) begin dut_acks++; last_ack_cyc = cyc; end
      if (bif.rvalid) begin rv_count++; last_rv_cyc = cyc; rd_log.push_back(bif.rdata); end
      if (bif.bus_req && bif.bus_ready) begin
        pend_addr.push_back(bif.bus_addr);
        pend_due.push_back(cyc + LAT);
        acc_log.push_back(bif.bus_addr);
      end
      if (resp_real) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
    cyc++;
  end

  task automatic start_fill(input logic [29:0] addr, input logic [RW-1:0] rlen);
    int acks0;
    acks0 = dut_acks;
    bif.req = 1'b1; bif.req_addr = addr; bif.req_rlen = rlen;
    for (int i = 0; (i < 50) && (dut_acks == acks0); i++) @(negedge clk);
    chk("ack_seen", 32'(dut_acks - acks0), 32'd1);
    bif.req = 1'b0; bif.req_addr = 30'h3FFF_FFFF; bif.req_rlen = '1;
  endtask

  task automatic wait_done(input int target);
    int i;
    i = 0;
    while ((fills_done < target) && (i < 200)) begin @(negedge clk); i++; end
    chk("fill_done_in_time", 32'(fills_done >= target), 32'd1);
  endtask

  function automatic logic [31:0] at(input int idx, input logic [31:0] q[$]);
    return (q.size() > idx) ? q[idx] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int target;
    int a0;
    int rv0;
    int gap;
    int i;
    bif.req = 1'b0; bif.req_addr = 30'd0; bif.req_rlen = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_req_ack", 32'(bif.req_ack), 32'd0);
    chk("rst_rvalid", 32'(bif.rvalid), 32'd0);
    chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_perr", 32'(bif.protocol_err), 32'd0);
    chk("rst_rdata", bif.rdata, 32'd0);

    // aligned fill
    @(negedge clk);
    acc_log.delete(); rd_log.delete(); a0 = dut_acks; target = fills_done + 1;
    start_fill(30'h100, 5'd7);
    wait_done(target);
    #3;
    chk("al_busy_after", 32'(bif.busy), 32'd0);
    chk("al_acc_n", 32'(acc_log.size()), 32'd8);
    chk("al_addr0", at(0, acc_log), 32'h0000_0400);
    chk("al_addr7", at(7, acc_log), 32'h0000_041C);
    chk("al_beats", 32'(rd_log.size()), 32'd8);
    chk("al_rdata0", at(0, rd_log), 32'hC0DE_0100);
    chk("al_rdata7", at(7, rd_log), 32'hC0DE_0107);
    chk("al_ack_cycles", 32'(dut_acks - a0), 32'd1);

    // unaligned request starts at word 0 of the line
    @(negedge clk);
    acc_log.delete(); rd_log.delete(); target = fills_done + 1;
    start_fill(30'h105, 5'd7);
    wait_done(target);
    chk("ua_addr0", at(0, acc_log), 32'h0000_0400);
    chk("ua_addr7", at(7, acc_log), 32'h0000_041C);
    chk("ua_rdata0", at(0, rd_log), 32'hC0DE_0100);

    // outstanding limit with responses withheld
    @(negedge clk);
    acc_log.delete(); rd_log.delete(); target = fills_done + 1;
    hold = 1'b1; full_resp_req_seen = 1'b0;
    start_fill(30'h200, 5'd7);
    repeat (10) @(negedge clk);
    #3;
    chk("ol_acc_n", 32'(acc_log.size()), 32'd4);
    chk("ol_bus_req_off", 32'(bif.bus_req), 32'd0);
    @(negedge clk);
    hold = 1'b0;
    wait_done(target);
    chk("ol_resp_reopens", 32'(full_resp_req_seen), 32'd1);
    chk("ol_acc_total", 32'(acc_log.size()), 32'd8);
    chk("ol_rdata0", at(0, rd_log), 32'hC0DE_0200);

    // backpressure: ready pattern 1,0,0,1
    @(negedge clk);
    acc_log.delete(); rd_log.delete(); target = fills_done + 1;
    ready_mode = 1'b1;
    start_fill(30'h04A, 5'd3);
    wait_done(target);
    ready_mode = 1'b0;
    chk("bp_acc_n", 32'(acc_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_addr", at(k, acc_log), 32'h0000_0120 + 32'(4 * k));
    chk("bp_rdata0", at(0, rd_log), 32'hC0DE_0048);

    // back-to-back with req held high
    @(negedge clk);
    rd_log.delete(); target = fills_done + 2; a0 = dut_acks;
    bif.req = 1'b1; bif.req_addr = 30'h010; bif.req_rlen = 5'd3;
    for (i = 0; (i < 50) && (dut_acks == a0); i++) @(negedge clk);
    bif.req_addr = 30'h020;
    for (i = 0; (i < 200) && (dut_acks < a0 + 2); i++) @(negedge clk);
    gap = last_ack_cyc - last_rv_cyc;
    bif.req = 1'b0;
    chk("b2b_acks", 32'(dut_acks - a0), 32'd2);
    chk("b2b_ack_gap", 32'(gap), 32'd1);
    wait_done(target);
    chk("b2b_rdata0", at(0, rd_log), 32'hC0DE_0010);
    chk("b2b_rdata4", at(4, rd_log), 32'hC0DE_0020);

    // spurious response while idle
    @(negedge clk);
    rv0 = rv_count;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #3;
    chk("sp_perr", 32'(bif.protocol_err), 32'd1);
    chk("sp_no_rvalid", 32'(bif.rvalid), 32'd0);
    chk("sp_rv_count", 32'(rv_count - rv0), 32'd0);

    // reset after three of eight beats, then a clean fill
    @(negedge clk);
    rv0 = rv_count;
    start_fill(30'h300, 5'd7);
    for (i = 0; (i < 100) && (rv_count < rv0 + 3); i++) @(negedge clk);
    chk("mr_three_beats", 32'(rv_count - rv0), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("mr_req_ack", 32'(bif.req_ack), 32'd0);
    chk("mr_rvalid", 32'(bif.rvalid), 32'd0);
    chk("mr_bus_req", 32'(bif.bus_req), 32'd0);
    chk("mr_busy", 32'(bif.busy), 32'd0);
    chk("mr_perr", 32'(bif.protocol_err), 32'd0);
    chk("mr_rdata", bif.rdata, 32'd0);
    @(negedge clk);
    acc_log.delete(); rd_log.delete(); target = fills_done + 1;
    start_fill(30'h308, 5'd7);
    wait_done(target);
    chk("mr_acc_n", 32'(acc_log.size()), 32'd8);
    chk("mr_addr0", at(0, acc_log), 32'h0000_0C20);
    chk("mr_rdata7", at(7, rd_log), 32'hC0DE_030F);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
